// File: rtl/fix_sm_accum.sv
// Sums LEN sign-magnitude samples into a wide accumulator; emits one saturated sign-magnitude result per block.
// Result valid 2 cycles after the last accept; in_ready drops from block end until out_ready takes the result.
module fix_sm_accum #(
  parameter int N   = 32,
  parameter int LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N+1:0] in_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_data,
  output logic         out_sat
);

  localparam int ACC_W = N + 3 + $clog2(LEN);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [ACC_W-1:0] MAG_MAX  = {{(ACC_W-N){1'b0}}, {N{1'b1}}};

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_CONV  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [N:0]               out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0]  samp_mag;
  logic signed [ACC_W-1:0]  samp_v;
  logic [ACC_W-1:0]         acc_abs;
  logic                     acc_neg;
  logic                     accept;

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    // Negating a zero magnitude yields zero, so negative zero needs no special case.
    samp_mag = {{(ACC_W-N-1){1'b0}}, in_sum[N:0]};
    samp_v   = in_sum[N+1] ? -samp_mag : samp_mag;
    acc_neg  = acc_q[ACC_W-1];
    acc_abs  = acc_neg ? -acc_q : acc_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          acc_d = (cnt_q == '0) ? samp_v : acc_q + samp_v;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_CONV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_CONV: begin
        if (acc_abs > MAG_MAX) begin
          out_data_d = {acc_neg, {N{1'b1}}};
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = {acc_neg, acc_abs[N-1:0]};
          out_sat_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fix_sm_accum.sv
// Directed plus randomized bench for fix_sm_accum (N=32, LEN=4) against a queue-based sum model.
module tb_fix_sm_accum;

  localparam int N   = 32;
  localparam int LEN = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N+1:0] in_sum = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N:0]   out_data;
  logic         out_sat;

  int errors = 0;
  int checks = 0;
  longint model_q[$];

  fix_sm_accum #(.N(N), .LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {sign, mag} and saturation flag from the plain sum of the block.
  task automatic model_result(output logic [N:0] exp_data, output logic exp_sat);
    longint s;
    longint a;
    logic [63:0] au;
    logic neg;
    s = 0;
    foreach (model_q[i]) s += model_q[i];
    neg = (s < 0);
    a   = neg ? -s : s;
    au  = 64'(a);
    exp_sat = (au > 64'h0000_0000_FFFF_FFFF);
    exp_data = exp_sat ? {neg, 32'hFFFF_FFFF} : {neg, au[31:0]};
  endtask

  task automatic send(input logic sgn, input logic [N:0] mag, input int gap);
    in_sum   = {sgn, mag};
    in_valid = 1'b1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    model_q.push_back(sgn ? -longint'({31'b0, mag}) : longint'({31'b0, mag}));
    for (int g = 0; g < gap; g++) begin
      cycle();
      chk("in_ready_gap", 64'(in_ready), 64'd1);
    end
  endtask

  // Called right after the LEN-th accept edge; checks CONV, HOLD for hold cycles, then release.
  task automatic finish_block(input int hold);
    logic [N:0] exp_data;
    logic exp_sat;
    model_result(exp_data, exp_sat);
    chk("conv_in_ready", 64'(in_ready), 64'd0);
    chk("conv_out_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("result_valid", 64'(out_valid), 64'd1);
    chk("result_data", 64'(out_data), 64'(exp_data));
    chk("result_sat", 64'(out_sat), 64'(exp_sat));
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    // Upstream presents a sample during the hold; it must not be consumed.
    in_valid = (hold > 0);
    in_sum   = {1'b0, 33'h0_0000_0077};
    for (int h = 0; h < hold; h++) begin
      cycle();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data_stable", 64'(out_data), 64'(exp_data));
      chk("hold_sat_stable", 64'(out_sat), 64'(exp_sat));
      chk("hold_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    model_q.delete();
  endtask

  initial begin
    logic sgn;
    logic [N:0] mag;
    logic [63:0] r64;

    // 1: reset held 2 cycles with in_valid high
    rst = 1'b1;
    in_valid = 1'b1;
    in_sum = {1'b0, 33'h0_0000_00FF};
    cycle();
    cycle();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;

    // 2: +5,+7,-3,+1 with a 2-cycle gap after the 2nd
    send(1'b0, 33'd5, 0);
    send(1'b0, 33'd7, 2);
    send(1'b1, 33'd3, 0);
    send(1'b0, 33'd1, 0);
    finish_block(0);
    chk("t2_const_data", 64'(out_data), 64'h0_0000_000A);

    // 3: cancellation to zero including negative zero
    send(1'b0, 33'h10, 0);
    send(1'b1, 33'h10, 0);
    send(1'b1, 33'h0, 0);
    send(1'b0, 33'h0, 0);
    finish_block(1);
    chk("t3_zero_data", 64'(out_data), 64'h0);

    // 4: positive and negative saturation
    for (int i = 0; i < LEN; i++) send(1'b0, 33'h1_FFFF_FFFF, 0);
    finish_block(0);
    chk("t4_pos_sat_data", 64'(out_data), 64'h0_FFFF_FFFF);
    chk("t4_pos_sat_flag", 64'(out_sat), 64'd1);
    for (int i = 0; i < LEN; i++) send(1'b1, 33'h1_FFFF_FFFF, 0);
    finish_block(0);
    chk("t4_neg_sat_data", 64'(out_data), 64'h1_FFFF_FFFF);
    chk("t4_neg_sat_flag", 64'(out_sat), 64'd1);

    // 5: long backpressure, then a block proving the held sample was not taken
    send(1'b0, 33'd2, 0);
    send(1'b0, 33'd2, 0);
    send(1'b0, 33'd2, 0);
    send(1'b0, 33'd2, 0);
    finish_block(5);
    send(1'b0, 33'd1, 0);
    send(1'b0, 33'd1, 0);
    send(1'b0, 33'd1, 0);
    send(1'b0, 33'd1, 0);
    finish_block(0);
    chk("t5_after_hold_data", 64'(out_data), 64'h0_0000_0004);

    // 6: reset discards a partial block
    send(1'b0, 33'd9, 0);
    send(1'b0, 33'd9, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_q.delete();
    send(1'b0, 33'd1, 0);
    send(1'b0, 33'd2, 0);
    send(1'b0, 33'd3, 0);
    send(1'b0, 33'd4, 0);
    finish_block(0);
    chk("t6_partial_rst_data", 64'(out_data), 64'h0_0000_000A);

    // 6b: reset while a result is held
    for (int i = 0; i < LEN; i++) send(1'b0, 33'd3, 0);
    cycle();
    chk("t6_hold_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    model_q.delete();
    chk("t6_rst_hold_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_hold_in_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_hold_data", 64'(out_data), 64'd0);

    // Randomized blocks against the sum model
    for (int b = 0; b < 30; b++) begin
      for (int s = 0; s < LEN; s++) begin
        sgn = 1'($urandom_range(0, 1));
        r64 = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: mag = 33'($urandom_range(0, 255));
          1: mag = r64[32:0];
          2: mag = 33'h1_FFFF_FFFF;
          default: mag = '0;
        endcase
        send(sgn, mag, (s == LEN - 1) ? 0 : int'($urandom_range(0, 2)));
      end
      finish_block(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
